// File: rtl/slow_clk_rx.sv
// slow_clk_rx: brings a slow clock/strobe into clk as rise/fall enables, measures its period, flags stalls.
// Optional period capture with valid/ack handshake is built when SLOW_CLK_PERIOD_MEAS_EN is defined.
module slow_clk_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 536870912
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    output logic             step,
    output logic             fall,
    output logic             level,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ack,
    output logic             overrun,
    output logic             stalled
);

    typedef enum logic [1:0] {S_IDLE, S_MEAS, S_STALL} state_t;

    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;
    logic                   fall_d;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;

    assign level   = sync[SYNC_STAGES-1];
    assign rise    = level & ~prev;
    assign fall_d  = ~level & prev;
    assign cnt_inc = cnt + CNT_W'(1);

    // synchronizer chain, previous-level copy and registered edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
            step <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], slow_clk};
            prev <= level;
            step <= rise;
            fall <= fall_d;
        end
    end

    // rise-to-rise counter and stall detection; a rise always beats the timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            stalled <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state <= S_MEAS;
                        cnt   <= '0;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        cnt <= '0;
                    end else if (cnt_inc == TO_M1) begin
                        state   <= S_STALL;
                        stalled <= 1'b1;
                        cnt     <= cnt_inc;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_STALL: begin
                    if (rise) begin
                        state   <= S_MEAS;
                        stalled <= 1'b0;
                        cnt     <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef SLOW_CLK_PERIOD_MEAS_EN
    logic capture;

    assign capture = (state == S_MEAS) && rise;

    // period capture with valid/ack handshake; unacknowledged overwrite sets sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (capture) begin
            period       <= cnt_inc;
            period_valid <= 1'b1;
            if (period_valid && !period_ack) overrun <= 1'b1;
        end else if (period_ack) begin
            period_valid <= 1'b0;
        end
    end
`else
    logic unused_ack;

    assign unused_ack   = period_ack;
    assign period       = '0;
    assign period_valid = 1'b0;
    assign overrun      = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clk_rx.sv
// tb_slow_clk_rx: directed table-driven bench for slow_clk_rx (SYNC_STAGES=2, CNT_W=8, TIMEOUT_CYCLES=40).
module tb_slow_clk_rx;

    localparam bit MEAS =
`ifdef SLOW_CLK_PERIOD_MEAS_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       slow_clk = 1'b0;
    logic       period_ack = 1'b0;
    logic       step, fall, level, period_valid, overrun, stalled;
    logic [7:0] period;

    int n_chk = 0;
    int n_fail = 0;

    slow_clk_rx #(.SYNC_STAGES(2), .CNT_W(8), .TIMEOUT_CYCLES(40)) dut (
        .clk(clk), .rst(rst), .slow_clk(slow_clk), .step(step), .fall(fall),
        .level(level), .period(period), .period_valid(period_valid),
        .period_ack(period_ack), .overrun(overrun), .stalled(stalled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, sc, ack;
        int         n;
        logic       step, fall, level;
        logic [7:0] period;
        logic       pv, ov, st;
    } vec_t;

    typedef struct {
        int         at;
        logic       step, fall, level;
        logic [7:0] period;
        logic       pv, ov, st;
    } chk_t;

    vec_t vt[14];
    chk_t ck[21];

    function automatic logic [13:0] pack(logic s, logic f, logic l, logic [7:0] p, logic v, logic o, logic t);
        return {s, f, l, MEAS ? p : 8'd0, MEAS & v, MEAS & o, t};
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = {step, fall, level, period, period_valid, overrun, stalled};
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got {step,fall,level,period,pv,ov,stalled}=%b_%b_%b_%0d_%b_%b_%b expected %b_%b_%b_%0d_%b_%b_%b",
                     name, got[13], got[12], got[11], got[10:3], got[2], got[1], got[0],
                     exp[13], exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic a);
        rst = r;
        slow_clk = s;
        period_ack = a;
        @(posedge clk);
        #1;
    endtask

    function automatic logic wave(int v);
        if (v >= 103 && v <= 162) return 1'b0;
        if (v >= 163) return ((v - 163) % 16) < 8;
        return ((v - 15) % 16) < 8;
    endfunction

    initial begin
        int vc;
        int j;
        vt[0]  = '{1, 0, 0, 5,  0, 0, 0, 0,  0, 0, 0};
        vt[1]  = '{0, 0, 0, 10, 0, 0, 0, 0,  0, 0, 0};
        vt[2]  = '{0, 1, 0, 1,  0, 0, 0, 0,  0, 0, 0};
        vt[3]  = '{0, 1, 0, 1,  0, 0, 1, 0,  0, 0, 0};
        vt[4]  = '{0, 1, 0, 1,  1, 0, 1, 0,  0, 0, 0};
        vt[5]  = '{0, 1, 0, 5,  0, 0, 1, 0,  0, 0, 0};
        vt[6]  = '{0, 0, 0, 1,  0, 0, 1, 0,  0, 0, 0};
        vt[7]  = '{0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0};
        vt[8]  = '{0, 0, 0, 1,  0, 1, 0, 0,  0, 0, 0};
        vt[9]  = '{0, 0, 0, 5,  0, 0, 0, 0,  0, 0, 0};
        vt[10] = '{0, 1, 0, 1,  0, 0, 0, 0,  0, 0, 0};
        vt[11] = '{0, 1, 0, 1,  0, 0, 1, 0,  0, 0, 0};
        vt[12] = '{0, 1, 0, 1,  1, 0, 1, 16, 1, 0, 0};
        vt[13] = '{0, 1, 0, 5,  0, 0, 1, 16, 1, 0, 0};

        ck[0]  = '{39,  0, 0, 1, 16, 1, 0, 0};
        ck[1]  = '{40,  0, 0, 0, 16, 0, 0, 0};
        ck[2]  = '{41,  0, 1, 0, 16, 0, 0, 0};
        ck[3]  = '{47,  0, 0, 0, 16, 0, 0, 0};
        ck[4]  = '{49,  1, 0, 1, 16, 1, 0, 0};
        ck[5]  = '{50,  0, 0, 1, 16, 1, 0, 0};
        ck[6]  = '{65,  1, 0, 1, 16, 1, 0, 0};
        ck[7]  = '{81,  1, 0, 1, 16, 1, 1, 0};
        ck[8]  = '{82,  0, 0, 1, 16, 0, 1, 0};
        ck[9]  = '{97,  1, 0, 1, 16, 1, 1, 0};
        ck[10] = '{98,  0, 0, 1, 16, 0, 1, 0};
        ck[11] = '{135, 0, 0, 0, 16, 0, 1, 0};
        ck[12] = '{136, 0, 0, 0, 16, 0, 1, 1};
        ck[13] = '{164, 0, 0, 1, 16, 0, 1, 1};
        ck[14] = '{165, 1, 0, 1, 16, 0, 1, 0};
        ck[15] = '{181, 1, 0, 1, 16, 1, 1, 0};
        ck[16] = '{182, 0, 0, 1, 16, 1, 1, 0};
        ck[17] = '{204, 0, 0, 0, 16, 1, 1, 0};
        ck[18] = '{205, 0, 0, 0, 0,  0, 0, 0};
        ck[19] = '{213, 1, 0, 1, 0,  0, 0, 0};
        ck[20] = '{229, 1, 0, 1, 16, 1, 0, 0};

        vc = 0;
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < vt[i].n; k++) begin
                cyc(vt[i].rst, vt[i].sc, vt[i].ack);
                check($sformatf("vec%0d", vc),
                      pack(vt[i].step, vt[i].fall, vt[i].level, vt[i].period, vt[i].pv, vt[i].ov, vt[i].st));
                vc++;
            end
        end

        j = 0;
        for (int v = 39; v <= 230; v++) begin
            cyc(v == 205, wave(v), v == 40 || v == 65 || v == 82 || v == 98);
            if (j < 21 && ck[j].at == v) begin
                check($sformatf("seq%0d", v),
                      pack(ck[j].step, ck[j].fall, ck[j].level, ck[j].period, ck[j].pv, ck[j].ov, ck[j].st));
                j++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
